// File: rtl/cpu_pkg.sv
// Shared MIPS core definitions: opcode/funct encodings, ALU operation codes
// and the control bundle handed from decode to execute.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_LINK = 5'd31;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_LUI  = 4'd12
  } aluop_e;

  typedef enum logic [1:0] {IMM_SIGN, IMM_ZERO, IMM_UPPER} imm_sel_e;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   alusrc;
    logic   branch;
    logic   bne;
    logic   jump;
    logic   jr;
    logic   link;
    logic   illegal;
    aluop_e aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(0);

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-stage bus: IF/ID inputs, register file read/write-back ports,
// hazard inputs and the registered ID/EX outputs.
interface id_ex_stage_if #(parameter int XLEN = 32, parameter int REG_AW = 5);
  logic              id_valid;
  logic [31:0]       id_inst;
  logic [XLEN-1:0]   id_pc4;
  logic [REG_AW-1:0] RX, RY;
  logic [XLEN-1:0]   busX, busY;
  logic              wb_wen;
  logic [REG_AW-1:0] wb_rw;
  logic [XLEN-1:0]   wb_busW;
  logic              ex_memread_i;
  logic [REG_AW-1:0] ex_rt_i;
  logic              mem_stall, flush, stall_out;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_busX, ex_busY, ex_imm, ex_pc4;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dst;
  logic              ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc;
  logic              ex_branch, ex_bne, ex_jump, ex_jr, ex_link, ex_illegal;
  logic [3:0]        ex_aluop;
  logic [4:0]        ex_shamt;

  modport master (
    output id_valid, id_inst, id_pc4, busX, busY, wb_wen, wb_rw, wb_busW,
           ex_memread_i, ex_rt_i, mem_stall, flush,
    input  RX, RY, stall_out, ex_valid, ex_busX, ex_busY, ex_imm, ex_pc4,
           ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           ex_alusrc, ex_branch, ex_bne, ex_jump, ex_jr, ex_link, ex_illegal,
           ex_aluop, ex_shamt
  );

  modport slave (
    input  id_valid, id_inst, id_pc4, busX, busY, wb_wen, wb_rw, wb_busW,
           ex_memread_i, ex_rt_i, mem_stall, flush,
    output RX, RY, stall_out, ex_valid, ex_busX, ex_busY, ex_imm, ex_pc4,
           ex_rs, ex_rt, ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           ex_alusrc, ex_branch, ex_bne, ex_jump, ex_jr, ex_link, ex_illegal,
           ex_aluop, ex_shamt
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational MIPS instruction decoder: control bundle, register fields,
// destination register and extended immediate.
module ctrl_decoder
  import cpu_pkg::*;
#(parameter int XLEN = 32) (
  input  logic [31:0]     inst,
  output ctrl_t           ctrl,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      dst,
  output logic [4:0]      shamt,
  output logic            reads_rt,
  output logic [XLEN-1:0] imm
);
  logic [5:0]  op, fn;
  logic [15:0] imm16;
  imm_sel_e    imm_sel;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign shamt = inst[10:6];
  assign fn    = inst[5:0];
  assign imm16 = inst[15:0];

  always_comb begin
    ctrl     = CTRL_NONE;
    dst      = rt;
    reads_rt = 1'b0;
    imm_sel  = IMM_SIGN;
    unique case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        dst           = inst[15:11];
        reads_rt      = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: ctrl.aluop = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl.aluop = ALU_SUB;
          FN_AND:          ctrl.aluop = ALU_AND;
          FN_OR:           ctrl.aluop = ALU_OR;
          FN_XOR:          ctrl.aluop = ALU_XOR;
          FN_NOR:          ctrl.aluop = ALU_NOR;
          FN_SLT:          ctrl.aluop = ALU_SLT;
          FN_SLTU:         ctrl.aluop = ALU_SLTU;
          FN_SLL:          ctrl.aluop = ALU_SLL;
          FN_SRL:          ctrl.aluop = ALU_SRL;
          FN_SRA:          ctrl.aluop = ALU_SRA;
          FN_JR: begin
            ctrl.regwrite = 1'b0;
            ctrl.jr       = 1'b1;
          end
          default: begin
            ctrl         = CTRL_NONE;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        case (op)
          OP_SLTI:  ctrl.aluop = ALU_SLT;
          OP_SLTIU: ctrl.aluop = ALU_SLTU;
          OP_ANDI:  begin ctrl.aluop = ALU_AND; imm_sel = IMM_ZERO;  end
          OP_ORI:   begin ctrl.aluop = ALU_OR;  imm_sel = IMM_ZERO;  end
          OP_XORI:  begin ctrl.aluop = ALU_XOR; imm_sel = IMM_ZERO;  end
          OP_LUI:   begin ctrl.aluop = ALU_LUI; imm_sel = IMM_UPPER; end
          default:  ctrl.aluop = ALU_ADD;
        endcase
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        reads_rt      = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.bne    = (op == OP_BNE);
        ctrl.aluop  = ALU_SUB;
        reads_rt    = 1'b1;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.link     = 1'b1;
        ctrl.regwrite = 1'b1;
        dst           = REG_LINK;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // writes to $0 are architecturally discarded; drop them here so EX/WB never see them
    if (dst == REG_ZERO) ctrl.regwrite = 1'b0;
  end

  always_comb begin
    unique case (imm_sel)
      IMM_ZERO:  imm = {{(XLEN-16){1'b0}}, imm16};
      IMM_UPPER: imm = {{(XLEN-32){1'b0}}, imm16, 16'h0000};
      default:   imm = {{(XLEN-16){imm16[15]}}, imm16};
    endcase
  end
endmodule

// File: rtl/id_ex_stage.sv
// Decode/operand-fetch stage: register file addressing, write-back bypass,
// load-use hazard detection and the ID/EX pipeline register.
module id_ex_stage
  import cpu_pkg::*;
#(parameter int XLEN = 32, parameter int REG_AW = 5) (
  input  logic          Clk,
  input  logic          Reset,
  id_ex_stage_if.slave  bus
);
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   x, y, imm, pc4;
    logic [REG_AW-1:0] rs, rt, dst;
    logic [4:0]        shamt;
    ctrl_t             ctrl;
  } idex_t;

  ctrl_t             dec_ctrl;
  logic [4:0]        dec_rs, dec_rt, dec_dst, dec_shamt;
  logic              dec_reads_rt;
  logic [XLEN-1:0]   dec_imm;
  logic [XLEN-1:0]   op_x, op_y;
  logic              load_use, bubble;
  idex_t             d, q;

  ctrl_decoder #(.XLEN(XLEN)) u_dec (
    .inst     (bus.id_inst),
    .ctrl     (dec_ctrl),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .dst      (dec_dst),
    .shamt    (dec_shamt),
    .reads_rt (dec_reads_rt),
    .imm      (dec_imm)
  );

  assign bus.RX = dec_rs;
  assign bus.RY = dec_rt;

  // write-back lands this same cycle, so forward it over the stale register file read
  assign op_x = (bus.RX == '0) ? '0 :
                (bus.wb_wen && bus.wb_rw == bus.RX) ? bus.wb_busW : bus.busX;
  assign op_y = (bus.RY == '0) ? '0 :
                (bus.wb_wen && bus.wb_rw == bus.RY) ? bus.wb_busW : bus.busY;

  assign load_use = bus.ex_memread_i && (bus.ex_rt_i != '0) && bus.id_valid &&
                    ((bus.ex_rt_i == bus.RX) || (dec_reads_rt && bus.ex_rt_i == bus.RY));
  assign bus.stall_out = load_use && !bus.mem_stall && !bus.flush;
  assign bubble = bus.flush || load_use || !bus.id_valid;

  always_comb begin
    d = '0;
    if (!bubble) begin
      d.valid = 1'b1;
      d.x     = op_x;
      d.y     = op_y;
      d.imm   = dec_imm;
      d.pc4   = bus.id_pc4;
      d.rs    = dec_rs;
      d.rt    = dec_rt;
      d.dst   = dec_dst;
      d.shamt = dec_shamt;
      d.ctrl  = dec_ctrl;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)               q <= '0;
    else if (!bus.mem_stall) q <= d;
  end

  assign bus.ex_valid    = q.valid;
  assign bus.ex_busX     = q.x;
  assign bus.ex_busY     = q.y;
  assign bus.ex_imm      = q.imm;
  assign bus.ex_pc4      = q.pc4;
  assign bus.ex_rs       = q.rs;
  assign bus.ex_rt       = q.rt;
  assign bus.ex_dst      = q.dst;
  assign bus.ex_shamt    = q.shamt;
  assign bus.ex_regwrite = q.ctrl.regwrite;
  assign bus.ex_memread  = q.ctrl.memread;
  assign bus.ex_memwrite = q.ctrl.memwrite;
  assign bus.ex_memtoreg = q.ctrl.memtoreg;
  assign bus.ex_alusrc   = q.ctrl.alusrc;
  assign bus.ex_branch   = q.ctrl.branch;
  assign bus.ex_bne      = q.ctrl.bne;
  assign bus.ex_jump     = q.ctrl.jump;
  assign bus.ex_jr       = q.ctrl.jr;
  assign bus.ex_link     = q.ctrl.link;
  assign bus.ex_illegal  = q.ctrl.illegal;
  assign bus.ex_aluop    = q.ctrl.aluop;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed ID vectors push hand-computed
// ID/EX snapshots; a monitor compares them one cycle later.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage dut (.Clk(clk), .Reset(rst), .bus(bus));

  typedef struct packed {
    logic        valid;
    logic [31:0] x, y, imm, pc4;
    logic [4:0]  rs, rt, dst, shamt;
    logic        regwrite, memread, memwrite, memtoreg, alusrc;
    logic        branch, bne, jump, jr, link, illegal;
    logic [3:0]  aluop;
  } snap_t;

  int    tests = 0;
  int    fails = 0;
  snap_t exp_q[$];
  string name_q[$];
  snap_t zero_s;
  snap_t e, s_hold;

  function automatic snap_t actual();
    snap_t s;
    s.valid = bus.ex_valid;  s.x = bus.ex_busX;  s.y = bus.ex_busY;
    s.imm = bus.ex_imm;      s.pc4 = bus.ex_pc4;
    s.rs = bus.ex_rs;  s.rt = bus.ex_rt;  s.dst = bus.ex_dst;  s.shamt = bus.ex_shamt;
    s.regwrite = bus.ex_regwrite;  s.memread = bus.ex_memread;
    s.memwrite = bus.ex_memwrite;  s.memtoreg = bus.ex_memtoreg;
    s.alusrc = bus.ex_alusrc;  s.branch = bus.ex_branch;  s.bne = bus.ex_bne;
    s.jump = bus.ex_jump;  s.jr = bus.ex_jr;  s.link = bus.ex_link;
    s.illegal = bus.ex_illegal;  s.aluop = bus.ex_aluop;
    return s;
  endfunction

  function automatic snap_t mk(logic [31:0] x, logic [31:0] y, logic [31:0] imm,
                               logic [31:0] pc4, logic [4:0] rs, logic [4:0] rt,
                               logic [4:0] dst, logic [4:0] shamt, logic [3:0] aluop);
    snap_t s;
    s = '0;
    s.valid = 1'b1;  s.x = x;  s.y = y;  s.imm = imm;  s.pc4 = pc4;
    s.rs = rs;  s.rt = rt;  s.dst = dst;  s.shamt = shamt;  s.aluop = aluop;
    return s;
  endfunction

  task automatic idle();
    bus.id_valid = 1'b0;  bus.id_inst = '0;  bus.id_pc4 = '0;
    bus.busX = '0;  bus.busY = '0;
    bus.wb_wen = 1'b0;  bus.wb_rw = '0;  bus.wb_busW = '0;
    bus.ex_memread_i = 1'b0;  bus.ex_rt_i = '0;
    bus.mem_stall = 1'b0;  bus.flush = 1'b0;
  endtask

  task automatic set_id(input logic [31:0] inst, input logic [31:0] pc4,
                        input logic [31:0] bx, input logic [31:0] by);
    idle();
    bus.id_valid = 1'b1;  bus.id_inst = inst;  bus.id_pc4 = pc4;
    bus.busX = bx;  bus.busY = by;
  endtask

  task automatic check_now(input snap_t exp_s, input string nm);
    snap_t a;
    a = actual();
    tests++;
    if (a !== exp_s) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, exp_s);
    end
  endtask

  // called at posedge+2 with inputs set; checks stall_out, queues the ID/EX snapshot
  task automatic cycle(input logic exp_stall, input snap_t exp_s, input string nm);
    #1;
    tests++;
    if (bus.stall_out !== exp_stall) begin
      fails++;
      $display("FAIL %s_stall: got %b expected %b", nm, bus.stall_out, exp_stall);
    end
    exp_q.push_back(exp_s);
    name_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    snap_t a, x;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = actual();
        tests++;
        if (a !== x) begin
          fails++;
          $display("FAIL %s: got %h expected %h", nm, a, x);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    zero_s = '0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    check_now(zero_s, "reset_state");
    rst = 1'b0;

    // lw $4,-4($1)
    set_id(32'h8C24FFFC, 32'h104, 32'h1000, 32'h2222);
    e = mk(32'h1000, 32'h2222, 32'hFFFFFFFC, 32'h104, 5'd1, 5'd4, 5'd4, 5'd31, ALU_ADD);
    e.regwrite = 1'b1;  e.memread = 1'b1;  e.memtoreg = 1'b1;  e.alusrc = 1'b1;
    cycle(1'b0, e, "lw_load");

    // asynchronous reset mid-cycle
    set_id(32'h20080005, 32'h108, 32'h1, 32'h2);
    #3;
    rst = 1'b1;
    #1;
    check_now(zero_s, "async_reset");
    @(posedge clk);
    #2;
    check_now(zero_s, "reset_hold");
    rst = 1'b0;

    // addi $8,$0,5
    set_id(32'h20080005, 32'h108, 32'hDEAD, 32'h11);
    e = mk(32'h0, 32'h11, 32'h5, 32'h108, 5'd0, 5'd8, 5'd8, 5'd0, ALU_ADD);
    e.regwrite = 1'b1;  e.alusrc = 1'b1;
    cycle(1'b0, e, "addi");

    // add $3,$1,$2 with $2 written back
    set_id(32'h00221820, 32'h10C, 32'h7, 32'h9);
    bus.wb_wen = 1'b1;  bus.wb_rw = 5'd2;  bus.wb_busW = 32'h55;
    e = mk(32'h7, 32'h55, 32'h1820, 32'h10C, 5'd1, 5'd2, 5'd3, 5'd0, ALU_ADD);
    e.regwrite = 1'b1;
    cycle(1'b0, e, "add_bypass_y");

    // or $10,$4,$4 with $4 written back
    set_id(32'h00845025, 32'h110, 32'h1, 32'h2);
    bus.wb_wen = 1'b1;  bus.wb_rw = 5'd4;  bus.wb_busW = 32'hABCD;
    e = mk(32'hABCD, 32'hABCD, 32'h5025, 32'h110, 5'd4, 5'd4, 5'd10, 5'd0, ALU_OR);
    e.regwrite = 1'b1;
    cycle(1'b0, e, "or_bypass_xy");

    // sub $5,$6,$4 behind lw $4
    set_id(32'h00C42822, 32'h114, 32'h60, 32'h40);
    bus.wb_rw = 5'd6;  bus.wb_busW = 32'h999;
    bus.ex_memread_i = 1'b1;  bus.ex_rt_i = 5'd4;
    cycle(1'b1, zero_s, "loaduse_bubble");

    set_id(32'h00C42822, 32'h114, 32'h60, 32'h40);
    bus.wb_rw = 5'd6;  bus.wb_busW = 32'h999;
    e = mk(32'h60, 32'h40, 32'h2822, 32'h114, 5'd6, 5'd4, 5'd5, 5'd0, ALU_SUB);
    e.regwrite = 1'b1;
    cycle(1'b0, e, "after_stall");

    set_id(32'h00C42822, 32'h118, 32'h60, 32'h40);
    bus.ex_memread_i = 1'b1;  bus.ex_rt_i = 5'd4;  bus.flush = 1'b1;
    cycle(1'b0, zero_s, "flush_over_loaduse");

    set_id(32'h00C42822, 32'h11C, 32'h61, 32'h41);
    s_hold = mk(32'h61, 32'h41, 32'h2822, 32'h11C, 5'd6, 5'd4, 5'd5, 5'd0, ALU_SUB);
    s_hold.regwrite = 1'b1;
    cycle(1'b0, s_hold, "pre_mem_stall");

    for (int i = 0; i < 3; i++) begin
      set_id(32'h00C42822, 32'h120, 32'h5, 32'h6);
      bus.ex_memread_i = 1'b1;  bus.ex_rt_i = 5'd4;
      bus.mem_stall = 1'b1;  bus.flush = (i == 1);
      cycle(1'b0, s_hold, "mem_stall_hold");
    end

    // ori $9,$0,0xFFFF
    set_id(32'h3409FFFF, 32'h124, 32'h77, 32'h88);
    e = mk(32'h0, 32'h88, 32'h0000FFFF, 32'h124, 5'd0, 5'd9, 5'd9, 5'd31, ALU_OR);
    e.regwrite = 1'b1;  e.alusrc = 1'b1;
    cycle(1'b0, e, "ori_zext");

    // lui $9,0x1234
    set_id(32'h3C091234, 32'h128, 32'h77, 32'h88);
    e = mk(32'h0, 32'h88, 32'h12340000, 32'h128, 5'd0, 5'd9, 5'd9, 5'd8, ALU_LUI);
    e.regwrite = 1'b1;  e.alusrc = 1'b1;
    cycle(1'b0, e, "lui_upper");

    // jal 0x100
    set_id(32'h0C000100, 32'h12C, 32'h77, 32'h88);
    e = mk(32'h0, 32'h0, 32'h100, 32'h12C, 5'd0, 5'd0, 5'd31, 5'd4, ALU_NOP);
    e.regwrite = 1'b1;  e.jump = 1'b1;  e.link = 1'b1;
    cycle(1'b0, e, "jal_link");

    // addi $0,$1,1
    set_id(32'h20200001, 32'h130, 32'h33, 32'h44);
    e = mk(32'h33, 32'h0, 32'h1, 32'h130, 5'd1, 5'd0, 5'd0, 5'd0, ALU_ADD);
    e.alusrc = 1'b1;
    cycle(1'b0, e, "addi_r0_nowrite");

    // opcode 0x3F
    set_id(32'hFC000000, 32'h134, 32'h33, 32'h44);
    e = mk(32'h0, 32'h0, 32'h0, 32'h134, 5'd0, 5'd0, 5'd0, 5'd0, ALU_NOP);
    e.illegal = 1'b1;
    cycle(1'b0, e, "illegal_op");

    // beq $1,$2 with the load targeting rt
    set_id(32'h10220003, 32'h138, 32'h5, 32'h6);
    bus.ex_memread_i = 1'b1;  bus.ex_rt_i = 5'd2;
    cycle(1'b1, zero_s, "beq_loaduse_rt");

    set_id(32'h10220003, 32'h138, 32'h5, 32'h6);
    e = mk(32'h5, 32'h6, 32'h3, 32'h138, 5'd1, 5'd2, 5'd2, 5'd0, ALU_SUB);
    e.branch = 1'b1;
    cycle(1'b0, e, "beq");

    // addi $9,$1,3 does not read rt, so a load into $9 is no hazard
    set_id(32'h20290003, 32'h13C, 32'h10, 32'h20);
    bus.ex_memread_i = 1'b1;  bus.ex_rt_i = 5'd9;
    e = mk(32'h10, 32'h20, 32'h3, 32'h13C, 5'd1, 5'd9, 5'd9, 5'd0, ALU_ADD);
    e.regwrite = 1'b1;  e.alusrc = 1'b1;
    cycle(1'b0, e, "itype_rt_no_hazard");

    idle();
    bus.id_inst = 32'h20080005;  bus.busY = 32'h11;
    cycle(1'b0, zero_s, "invalid_bubble");

    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
